// File: rtl/ni_pkg.sv
// rtl/ni_pkg.sv - shared flit codes, header geometry and FSM state codes for ni_inject
package ni_pkg;

    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    // Head payload field LSBs for the default 32-bit flit / 4-bit coordinate geometry
    localparam int HDR_DX_LSB  = 26;
    localparam int HDR_DY_LSB  = 22;
    localparam int HDR_SX_LSB  = 18;
    localparam int HDR_SY_LSB  = 14;
    localparam int HDR_LEN_LSB = 10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] VSEL = 2'd1;
    localparam logic [1:0] BODY = 2'd2;

endpackage

// File: rtl/ni_credit_ctr.sv
// rtl/ni_credit_ctr.sv - per-VC saturating credit counter with sticky overflow flag
module ni_credit_ctr
    import ni_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic avail,
    output logic ovf
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (inc && !dec) begin
            if (cnt_q == CW'(CREDITS)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(CREDITS);
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign avail = (cnt_q != '0);
    assign ovf   = ovf_q;

endmodule

// File: rtl/ni_inject.sv
// rtl/ni_inject.sv - NI injection stage (head/body/tail flits, per-VC credits); NI_PKT_STATS_EN adds pkt_cnt/flit_cnt
module ni_inject
    import ni_pkg::*;
#(
    parameter int DATAW   = 32,
    parameter int NVCH    = 2,
    parameter int VCHW    = 1,
    parameter int CREDITS = 4,
    parameter int ARRAYW  = 4,
    parameter int LENW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ARRAYW-1:0] my_xpos,
    input  logic [ARRAYW-1:0] my_ypos,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [ARRAYW-1:0] pkt_dst_x,
    input  logic [ARRAYW-1:0] pkt_dst_y,
    input  logic [LENW-1:0]   pkt_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATAW-3:0]  pl_data,
    output logic [DATAW-1:0]  odata,
    output logic              ovalid,
    output logic [VCHW-1:0]   ovch,
    input  logic [NVCH-1:0]   iack,
    input  logic [NVCH-1:0]   ilck,
    output logic              cr_err
`ifdef NI_PKT_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       flit_cnt
`endif
);

    localparam int PADW = DATAW - 2 - 4 * ARRAYW - LENW;

    logic [1:0]        state_q, state_d;
    logic [ARRAYW-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [LENW-1:0]   len_q, len_d, rem_q, rem_d;
    logic [VCHW-1:0]   cur_q, cur_d, rr_q, rr_d, ovch_q, ovch_d;
    logic              ovalid_q, ovalid_d;
    logic [DATAW-1:0]  odata_q, odata_d;

    logic [NVCH-1:0]   avail, ovf, elig, send_vec;
    logic              hi_found, lo_found, found;
    logic [VCHW-1:0]   hi_sel, lo_sel, sel;

    assign elig = ~ilck & avail;

    // Round-robin: lowest eligible VC at/after rr_q, else wrap to the lowest eligible overall
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int v = NVCH - 1; v >= 0; v--) begin
            if (elig[v]) begin
                lo_found = 1'b1;
                lo_sel   = VCHW'(v);
                if (VCHW'(v) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_sel   = VCHW'(v);
                end
            end
        end
        found = hi_found | lo_found;
        sel   = hi_found ? hi_sel : lo_sel;
    end

    always_comb begin
        state_d   = state_q;
        dst_x_d   = dst_x_q;
        dst_y_d   = dst_y_q;
        len_d     = len_q;
        rem_d     = rem_q;
        cur_d     = cur_q;
        rr_d      = rr_q;
        ovch_d    = ovch_q;
        odata_d   = odata_q;
        ovalid_d  = 1'b0;
        send_vec  = '0;
        pkt_ready = 1'b0;
        pl_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    dst_x_d = pkt_dst_x;
                    dst_y_d = pkt_dst_y;
                    len_d   = (pkt_len == '0) ? LENW'(1) : pkt_len;
                    rem_d   = (pkt_len == '0) ? LENW'(1) : pkt_len;
                    state_d = VSEL;
                end
            end
            VSEL: begin
                if (found) begin
                    odata_d = {(len_q == LENW'(1)) ? FT_HT : FT_HEAD,
                               dst_x_q, dst_y_q, my_xpos, my_ypos, len_q, {PADW{1'b0}}};
                    ovalid_d      = 1'b1;
                    ovch_d        = sel;
                    cur_d         = sel;
                    send_vec[sel] = 1'b1;
                    rr_d          = (sel == VCHW'(NVCH - 1)) ? '0 : sel + VCHW'(1);
                    state_d       = (len_q == LENW'(1)) ? IDLE : BODY;
                end
            end
            BODY: begin
                pl_ready = pl_valid && avail[cur_q];
                if (pl_ready) begin
                    odata_d         = {(rem_q == LENW'(2)) ? FT_TAIL : FT_BODY, pl_data};
                    ovalid_d        = 1'b1;
                    ovch_d          = cur_q;
                    send_vec[cur_q] = 1'b1;
                    rem_d           = rem_q - LENW'(1);
                    if (rem_q == LENW'(2)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            pkt_ready = 1'b0;
            pl_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dst_x_q  <= '0;
            dst_y_q  <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            cur_q    <= '0;
            rr_q     <= '0;
            ovch_q   <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dst_x_q  <= dst_x_d;
            dst_y_q  <= dst_y_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            cur_q    <= cur_d;
            rr_q     <= rr_d;
            ovch_q   <= ovch_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
        end
    end

    for (genvar v = 0; v < NVCH; v++) begin : g_cr
        ni_credit_ctr #(
            .CREDITS(CREDITS)
        ) u_cr (
            .clk  (clk),
            .rst  (rst),
            .inc  (iack[v]),
            .dec  (send_vec[v]),
            .avail(avail[v]),
            .ovf  (ovf[v])
        );
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;
    assign cr_err = |ovf;

`ifdef NI_PKT_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d, flit_cnt_q, flit_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        flit_cnt_d = flit_cnt_q;
        if (ovalid_d) begin
            flit_cnt_d = flit_cnt_q + 16'd1;
            if (odata_d[DATAW-1]) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign flit_cnt = flit_cnt_q;
`endif

endmodule

// File: tb/tb_ni_inject.sv
// tb/tb_ni_inject.sv - table-driven and directed-sequence bench for ni_inject
module tb_ni_inject;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  my_xpos, my_ypos;
    logic        pkt_valid, pkt_ready;
    logic [3:0]  pkt_dst_x, pkt_dst_y, pkt_len;
    logic        pl_valid, pl_ready;
    logic [29:0] pl_data;
    logic [31:0] odata;
    logic        ovalid;
    logic [0:0]  ovch;
    logic [1:0]  iack, ilck;
    logic        cr_err;
`ifdef NI_PKT_STATS_EN
    logic [15:0] pkt_cnt, flit_cnt;
`endif

    always #5 clk = ~clk;

    ni_inject dut (
        .clk      (clk),
        .rst      (rst),
        .my_xpos  (my_xpos),
        .my_ypos  (my_ypos),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_dst_x(pkt_dst_x),
        .pkt_dst_y(pkt_dst_y),
        .pkt_len  (pkt_len),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .pl_data  (pl_data),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch),
        .iack     (iack),
        .ilck     (ilck),
        .cr_err   (cr_err)
`ifdef NI_PKT_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .flit_cnt (flit_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic [3:0]  len;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic        plv;
        logic [29:0] pld;
        logic [1:0]  ack;
        logic [1:0]  lck;
        logic        e_pkt_rdy;
        logic        e_pl_rdy;
        logic        e_ovalid;
        logic [31:0] e_odata;
        logic        e_ovch;
    } vec_t;

    vec_t tbl[16];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic pv, logic [3:0] len, logic [3:0] dx, logic [3:0] dy,
                                logic plv, logic [29:0] pld, logic [1:0] ack, logic [1:0] lck,
                                logic epk, logic epl, logic eov, logic [31:0] eod, logic ech);
        vec_t v;
        v.rst = r; v.pv = pv; v.len = len; v.dx = dx; v.dy = dy;
        v.plv = plv; v.pld = pld; v.ack = ack; v.lck = lck;
        v.e_pkt_rdy = epk; v.e_pl_rdy = epl; v.e_ovalid = eov; v.e_odata = eod; v.e_ovch = ech;
        return v;
    endfunction

    function automatic logic [31:0] hdr(logic [1:0] ft, logic [3:0] dx, logic [3:0] dy,
                                        logic [3:0] sx, logic [3:0] sy, logic [3:0] len);
        return {ft, dx, dy, sx, sy, len, 10'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid = 1'b0; pkt_dst_x = '0; pkt_dst_y = '0; pkt_len = '0;
        pl_valid = 1'b0; pl_data = '0; iack = '0; ilck = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Five-flit packet on a fresh VC0: four flits leave, then the tail must stall on credit
    task automatic run5_to_stall(input string tag, input logic [3:0] dx, input logic [3:0] dy);
        pkt_valid = 1'b1; pkt_len = 4'd5; pkt_dst_x = dx; pkt_dst_y = dy;
        #1 chk({tag, "_pkt_rdy"}, 32'(pkt_ready), 32'd1);
        tick();
        pkt_valid = 1'b0; pl_valid = 1'b1; pl_data = 30'h100;
        tick();
        chk({tag, "_head_v"}, 32'(ovalid), 32'd1);
        chk({tag, "_head_d"}, odata, hdr(2'b01, dx, dy, my_xpos, my_ypos, 4'd5));
        chk({tag, "_head_vc"}, 32'(ovch), 32'd0);
        for (int i = 0; i < 3; i++) begin
            pl_data = 30'h100 + 30'(i);
            #1 chk({tag, "_body_rdy"}, 32'(pl_ready), 32'd1);
            tick();
            chk({tag, "_body_d"}, {31'd0, ovalid} == 32'd1 ? odata : 32'hDEAD_BEEF,
                {2'b00, 30'h100 + 30'(i)});
        end
        pl_data = 30'h1FF;
        #1 chk({tag, "_stall_rdy"}, 32'(pl_ready), 32'd0);
        tick();
        chk({tag, "_stall_v"}, 32'(ovalid), 32'd0);
    endtask

    initial begin
        tbl[0]  = mk(0, 1, 1, 2, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, hdr(2'b11, 2, 3, 0, 0, 1), 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 4, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 30'hA1, 0, 0, 0, 0, 1, hdr(2'b01, 7, 1, 0, 0, 4), 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 30'hA1, 0, 0, 0, 1, 1, {2'b00, 30'hA1}, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 30'hA2, 0, 0, 0, 1, 1, {2'b00, 30'hA2}, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 30'hA3, 0, 0, 0, 1, 1, {2'b10, 30'hA3}, 0);
        tbl[8]  = mk(0, 1, 2, 3, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 30'hB1, 0, 0, 0, 0, 1, hdr(2'b01, 3, 3, 0, 0, 2), 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 30'hB1, 0, 0, 0, 1, 1, {2'b10, 30'hB1}, 1);
        tbl[11] = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, hdr(2'b11, 1, 1, 0, 0, 1), 1);
        tbl[13] = mk(0, 1, 0, 4, 4, 0, 0, 2'b01, 0, 1, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, hdr(2'b11, 4, 4, 0, 0, 1), 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        my_xpos = 4'h0; my_ypos = 4'h0;
        idle_inputs();
        rst = 1'b1;
        tick();
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_odata", odata, 32'd0);
        chk("rst_ovch", 32'(ovch), 32'd0);
        chk("rst_pkt_rdy", 32'(pkt_ready), 32'd0);
        chk("rst_pl_rdy", 32'(pl_ready), 32'd0);
        chk("rst_cr_err", 32'(cr_err), 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; pkt_valid = tbl[i].pv; pkt_len = tbl[i].len;
            pkt_dst_x = tbl[i].dx; pkt_dst_y = tbl[i].dy; pl_valid = tbl[i].plv;
            pl_data = tbl[i].pld; iack = tbl[i].ack; ilck = tbl[i].lck;
            #1;
            chk($sformatf("tbl%0d_pkt_rdy", i), 32'(pkt_ready), 32'(tbl[i].e_pkt_rdy));
            chk($sformatf("tbl%0d_pl_rdy", i), 32'(pl_ready), 32'(tbl[i].e_pl_rdy));
            tick();
            chk($sformatf("tbl%0d_ovalid", i), 32'(ovalid), 32'(tbl[i].e_ovalid));
            if (tbl[i].e_ovalid) begin
                chk($sformatf("tbl%0d_odata", i), odata, tbl[i].e_odata);
                chk($sformatf("tbl%0d_ovch", i), 32'(ovch), 32'(tbl[i].e_ovch));
            end
        end
        rst = 1'b0;

        // Credit stall, released by a single ack on VC0
        my_xpos = 4'h9; my_ypos = 4'h6;
        do_reset();
        run5_to_stall("stall", 4'h5, 4'h6);
        iack = 2'b01;
        #1 chk("stall_ack_rdy", 32'(pl_ready), 32'd0);
        tick();
        iack = 2'b00;
        #1 chk("stall_rel_rdy", 32'(pl_ready), 32'd1);
        tick();
        chk("stall_tail_v", 32'(ovalid), 32'd1);
        chk("stall_tail_d", odata, {2'b10, 30'h1FF});
        pl_valid = 1'b0;
        #1 chk("stall_idle_rdy", 32'(pkt_ready), 32'd1);

        // Lock avoidance
        do_reset();
        ilck = 2'b01; pkt_valid = 1'b1; pkt_len = 4'd1; pkt_dst_x = 4'h1; pkt_dst_y = 4'h2;
        tick();
        pkt_valid = 1'b0;
        tick();
        chk("lck1_v", 32'(ovalid), 32'd1);
        chk("lck1_vc", 32'(ovch), 32'd1);
        tick();
        ilck = 2'b11; pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        tick();
        chk("lck2_wait1", 32'(ovalid), 32'd0);
        tick();
        chk("lck2_wait2", 32'(ovalid), 32'd0);
        ilck = 2'b10;
        tick();
        chk("lck2_v", 32'(ovalid), 32'd1);
        chk("lck2_vc", 32'(ovch), 32'd0);
        chk("lck2_d", odata, hdr(2'b11, 4'h1, 4'h2, 4'h9, 4'h6, 4'd1));
        ilck = 2'b00;

        // Ack coinciding with a send keeps credit0 at 4, so 5 flits go without a stall
        do_reset();
        pkt_valid = 1'b1; pkt_len = 4'd5; pkt_dst_x = 4'h8; pkt_dst_y = 4'h8;
        tick();
        pkt_valid = 1'b0; iack = 2'b01; pl_valid = 1'b1;
        tick();
        iack = 2'b00;
        chk("sim_head_v", 32'(ovalid), 32'd1);
        chk("sim_cr_err", 32'(cr_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pl_data = 30'h200 + 30'(i);
            #1 chk($sformatf("sim_rdy%0d", i), 32'(pl_ready), 32'd1);
            tick();
            chk($sformatf("sim_v%0d", i), 32'(ovalid), 32'd1);
            chk($sformatf("sim_d%0d", i), odata, {(i == 3) ? 2'b10 : 2'b00, 30'h200 + 30'(i)});
        end
        pl_valid = 1'b0;

        // Overflow flag is sticky until reset
        do_reset();
        iack = 2'b01;
        tick();
        iack = 2'b00;
        chk("ovf_set", 32'(cr_err), 32'd1);
        tick();
        tick();
        chk("ovf_hold", 32'(cr_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_clr", 32'(cr_err), 32'd0);

        // Reset mid-body abandons the packet and restores credits
        do_reset();
        pkt_valid = 1'b1; pkt_len = 4'd4; pkt_dst_x = 4'h2; pkt_dst_y = 4'h2;
        tick();
        pkt_valid = 1'b0; pl_valid = 1'b1; pl_data = 30'h55;
        tick();
        tick();
        chk("mid_body_v", 32'(ovalid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; pl_valid = 1'b0;
        chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
        #1 chk("mid_rst_idle", 32'(pkt_ready), 32'd1);
        run5_to_stall("post_rst", 4'h3, 4'h4);
        pl_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ni_inject.md
Name: ni_inject

Overview:
- Network-interface injection stage that sits directly upstream of a router's local input port.
- Accepts packet descriptors and payload words from a core, then emits head/body/tail flits on the router's input link (data, valid, VC).
- Tracks per-VC credits, which are returned through the router's per-VC ack lines.
- Honours the router's per-VC lock lines, so a new packet only starts on a free VC.

Parameters:
- DATAW, 32, flit width in bits; bits [DATAW-1:DATAW-2] are the flit type.
- NVCH, 2, number of virtual channels.
- VCHW, 1, VC index width, clog2(NVCH).
- CREDITS, 4, downstream buffer depth per VC; also the credit reset value.
- ARRAYW, 4, width of each mesh coordinate.
- LENW, 4, width of the packet-length field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- my_xpos  in  ARRAYW  local x coordinate, inserted into the header
- my_ypos  in  ARRAYW  local y coordinate, inserted into the header
- pkt_valid  in  1  packet descriptor valid
- pkt_ready  out  1  descriptor accepted
- pkt_dst_x  in  ARRAYW  destination x
- pkt_dst_y  in  ARRAYW  destination y
- pkt_len  in  LENW  total flits including the head
- pl_valid  in  1  payload word valid
- pl_ready  out  1  payload word consumed
- pl_data  in  DATAW-2  payload word
- odata  out  DATAW  flit to the router
- ovalid  out  1  flit valid; one-cycle pulse per flit
- ovch  out  VCHW  VC of the current flit
- iack  in  NVCH  per-VC credit return; one pulse = one slot freed
- ilck  in  NVCH  per-VC lock; 1 = VC owned by another packet
- cr_err  out  1  sticky credit-overflow error

Behaviour:
- Reset values:
  - ovalid=0, odata=0, ovch=0.
  - pkt_ready=0, pl_ready=0, cr_err=0.
  - All credits = CREDITS; FSM = IDLE.
- Reset mid-packet abandons the packet silently; no tail flit is emitted.
- Flit type codes: 01 head, 00 body, 10 tail, 11 head+tail.
- Head payload layout: {dst_x, dst_y, src_x, src_y, len, zero-pad}.
- FSM states:
  - IDLE: pkt_ready=1. On pkt_valid, latch dst and len into rem (len 0 is treated as 1), then go to VSEL.
  - VSEL: eligible VC v means ilck[v]==0 and credit[v]>0. Pick the lowest eligible index at or after a round-robin pointer. Then:
    - register the head flit (type 11 if len==1, else 01);
    - ovalid=1, ovch=v;
    - decrement credit[v] and advance the pointer to v+1;
    - go to IDLE if len==1, else BODY.
    - If no VC is eligible, stall in VSEL.
  - BODY: pl_ready = pl_valid && credit[cur]>0 (combinational).
    - On a transfer: register the flit (type 10 when rem==2, else 00), decrement rem and credit[cur].
    - After the tail, return to IDLE.
    - ilck is ignored mid-packet; cur stays fixed.
- Latency: a flit appears on odata/ovalid one cycle after its acceptance edge.
- Minimum head-to-head spacing is 2 cycles, because IDLE and VSEL are separate states.
- Credit update per VC each cycle:
  - +1 on iack[v];
  - −1 when a flit is sent on v;
  - unchanged when both happen together.
  - A +1 at CREDITS saturates and sets cr_err; cr_err clears only on rst.
- A flit is never emitted on a VC whose credit is 0.
- An iack on a VC other than cur is still counted.

Optional Feature:
- NI_PKT_STATS_EN defined:
  - adds outputs pkt_cnt[15:0] and flit_cnt[15:0];
  - both increment on each tail/head+tail flit and on each flit respectively;
  - both wrap modulo 2^16 and are 0 on rst.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package ni_pkg holds:
  - flit type localparams FT_HEAD, FT_BODY, FT_TAIL, FT_HT;
  - header field offsets;
  - the state enum IDLE/VSEL/BODY.
- One sub-module: ni_credit_ctr, a per-VC saturating credit counter with overflow flag, instantiated NVCH times.

Test Plan:
- Single-flit packet: len=1, dst=(2,3), my=(0,0), all VCs free → one flit, type 11, on VC0, credit0 goes 4→3; pkt_ready returns to 1 two cycles after acceptance.
- 4-flit packet with no acks, CREDITS=4: head, 2 bodies, then tail (type 10); credit0=0; a second packet waits in VSEL for VC1 and goes out on VC1.
- Credit stall: send 5-flit packets on VC0 with no iack → 4 flits go out, then pl_ready=0; one iack[0] pulse → the 5th flit, the tail, is sent the next cycle.
- Lock avoidance: ilck=2'b01 in VSEL → head on VC1; ilck=2'b11 → stall until ilck[0] drops, then head on VC0.
- Simultaneous iack[0] and send on VC0 → credit0 unchanged. iack[0] while credit0=4 → cr_err=1 and stays 1 until rst.
- rst asserted mid-BODY → next cycle ovalid=0, FSM in IDLE, credits=4; a new packet starts with a fresh head flit.
